// File: rtl/neuron_param_loader_pkg.sv
// Shared types, default widths and helpers for the neuron parameter loader.
`ifndef dataWidth
`define dataWidth 16
`endif

package neuron_param_loader_pkg;

    localparam int unsigned DATA_WIDTH_DEF = `dataWidth;
    localparam int unsigned CFG_WIDTH_DEF  = 2 * DATA_WIDTH_DEF + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BIAS   = 2'd1,
        ST_WEIGHT = 2'd2
    } load_state_e;

    // One bias word followed by all weights, for every neuron of the layer.
    function automatic int unsigned words_per_layer(input int unsigned num_neurons,
                                                    input int unsigned num_weight);
        return num_neurons * (num_weight + 1);
    endfunction

endpackage

// File: rtl/neuron_param_loader_counter.sv
// Nested weight/neuron counter: w_cnt wraps per neuron and carries into n_cnt.
module param_load_counter #(
    parameter int unsigned NUM_WEIGHT  = 128,
    parameter int unsigned NUM_NEURONS = 30,
    parameter int unsigned WCW         = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1,
    parameter int unsigned NCW         = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           en,
    output logic [WCW-1:0] w_cnt,
    output logic [NCW-1:0] n_cnt,
    output logic           last_weight_c,
    output logic           last_neuron_c
);

    logic [WCW-1:0] w_cnt_q, w_cnt_d;
    logic [NCW-1:0] n_cnt_q, n_cnt_d;

    assign last_weight_c = (w_cnt_q == WCW'(NUM_WEIGHT - 1));
    assign last_neuron_c = (n_cnt_q == NCW'(NUM_NEURONS - 1));
    assign w_cnt         = w_cnt_q;
    assign n_cnt         = n_cnt_q;

    always_comb begin
        w_cnt_d = w_cnt_q;
        n_cnt_d = n_cnt_q;
        if (clr) begin
            w_cnt_d = '0;
            n_cnt_d = '0;
        end else if (en) begin
            if (last_weight_c) begin
                w_cnt_d = '0;
                n_cnt_d = last_neuron_c ? '0 : n_cnt_q + NCW'(1);
            end else begin
                w_cnt_d = w_cnt_q + WCW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_cnt_q <= '0;
            n_cnt_q <= '0;
        end else begin
            w_cnt_q <= w_cnt_d;
            n_cnt_q <= n_cnt_d;
        end
    end

endmodule

// File: rtl/neuron_param_loader.sv
// Streams one layer's bias/weight words from a host stream into the neuron load ports.
module neuron_param_loader
    import neuron_param_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int unsigned NUM_WEIGHT   = 128,
    parameter int unsigned NUM_NEURONS  = 30,
    parameter int unsigned LAYER_NO     = 1,
    parameter int unsigned FIRST_NEURON = 0,
    parameter int unsigned CFG_WIDTH    = 2 * DATA_WIDTH + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DATA_WIDTH-1:0]  s_tdata,
    input  logic                   s_tvalid,
    input  logic                   s_tlast,
    output logic                   s_tready,
    output logic [DATA_WIDTH-1:0]  weight_value,
    output logic                   weight_valid,
    output logic [DATA_WIDTH-1:0]  bias_value,
    output logic [NUM_NEURONS-1:0] bias_valid,
    output logic [CFG_WIDTH-1:0]   cfg_layer_num,
    output logic [CFG_WIDTH-1:0]   cfg_neuron_num,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int unsigned WCW = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;
    localparam int unsigned NCW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

    load_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0]  weight_value_q, weight_value_d;
    logic                   weight_valid_q, weight_valid_d;
    logic [DATA_WIDTH-1:0]  bias_value_q, bias_value_d;
    logic [NUM_NEURONS-1:0] bias_valid_q, bias_valid_d;
    logic [CFG_WIDTH-1:0]   cfg_neuron_num_q, cfg_neuron_num_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic                   cnt_clr, cnt_en;
    logic [WCW-1:0]         w_cnt;
    logic [NCW-1:0]         n_cnt;
    logic                   last_weight_c, last_neuron_c;
    logic                   beat_c;

    param_load_counter #(
        .NUM_WEIGHT  (NUM_WEIGHT),
        .NUM_NEURONS (NUM_NEURONS),
        .WCW         (WCW),
        .NCW         (NCW)
    ) u_cnt (
        .clk           (clk),
        .rst           (rst),
        .clr           (cnt_clr),
        .en            (cnt_en),
        .w_cnt         (w_cnt),
        .n_cnt         (n_cnt),
        .last_weight_c (last_weight_c),
        .last_neuron_c (last_neuron_c)
    );

    // Neurons take a word every cycle, so readiness depends only on the state.
    assign s_tready = (state_q != ST_IDLE);
    assign beat_c   = s_tvalid & s_tready;

    always_comb begin
        state_d          = state_q;
        weight_value_d   = weight_value_q;
        weight_valid_d   = 1'b0;
        bias_value_d     = bias_value_q;
        bias_valid_d     = '0;
        cfg_neuron_num_d = cfg_neuron_num_q;
        busy_d           = busy_q;
        done_d           = 1'b0;
        err_d            = err_q;
        cnt_clr          = 1'b0;
        cnt_en           = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_BIAS;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    cnt_clr = 1'b1;
                end
            end
            ST_BIAS: begin
                if (beat_c) begin
                    bias_value_d = s_tdata;
                    bias_valid_d = NUM_NEURONS'(1) << n_cnt;
                    state_d      = ST_WEIGHT;
                    if (s_tlast) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            ST_WEIGHT: begin
                if (beat_c) begin
                    weight_value_d   = s_tdata;
                    weight_valid_d   = 1'b1;
                    cfg_neuron_num_d = CFG_WIDTH'(FIRST_NEURON) + CFG_WIDTH'(n_cnt);
                    cnt_en           = 1'b1;
                    if (last_weight_c && last_neuron_c) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        if (!s_tlast) err_d = 1'b1;
                    end else if (s_tlast) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end else if (last_weight_c) begin
                        state_d = ST_BIAS;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            weight_value_q   <= '0;
            weight_valid_q   <= 1'b0;
            bias_value_q     <= '0;
            bias_valid_q     <= '0;
            cfg_neuron_num_q <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            err_q            <= 1'b0;
        end else begin
            state_q          <= state_d;
            weight_value_q   <= weight_value_d;
            weight_valid_q   <= weight_valid_d;
            bias_value_q     <= bias_value_d;
            bias_valid_q     <= bias_valid_d;
            cfg_neuron_num_q <= cfg_neuron_num_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            err_q            <= err_d;
        end
    end

    assign weight_value   = weight_value_q;
    assign weight_valid   = weight_valid_q;
    assign bias_value     = bias_value_q;
    assign bias_valid     = bias_valid_q;
    assign cfg_layer_num  = CFG_WIDTH'(LAYER_NO);
    assign cfg_neuron_num = cfg_neuron_num_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_neuron_param_loader.sv
// Directed bench for neuron_param_loader on a 2-neuron, 4-weight layer starting at neuron 8.
module tb_neuron_param_loader;
    import neuron_param_loader_pkg::*;

    localparam int unsigned DW  = 16;
    localparam int unsigned NW  = 4;
    localparam int unsigned NN  = 2;
    localparam int unsigned FN  = 8;
    localparam int unsigned CW  = 2 * DW + 1;
    localparam int unsigned PER = NW + 1;

    logic          clk = 1'b0;
    logic          rst, start, s_tvalid, s_tlast;
    logic [DW-1:0] s_tdata;
    logic          s_tready, weight_valid, busy, done, err;
    logic [DW-1:0] weight_value, bias_value;
    logic [NN-1:0] bias_valid;
    logic [CW-1:0] cfg_layer_num, cfg_neuron_num;

    int            errors = 0;
    int            checks = 0;
    int            strobes;
    logic [DW-1:0] words [10];

    neuron_param_loader #(
        .DATA_WIDTH   (DW),
        .NUM_WEIGHT   (NW),
        .NUM_NEURONS  (NN),
        .LAYER_NO     (1),
        .FIRST_NEURON (FN),
        .CFG_WIDTH    (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .s_tdata        (s_tdata),
        .s_tvalid       (s_tvalid),
        .s_tlast        (s_tlast),
        .s_tready       (s_tready),
        .weight_value   (weight_value),
        .weight_valid   (weight_valid),
        .bias_value     (bias_value),
        .bias_valid     (bias_valid),
        .cfg_layer_num  (cfg_layer_num),
        .cfg_neuron_num (cfg_neuron_num),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " busy"}, 64'(busy), 64'd1);
        check({tag, " tready"}, 64'(s_tready), 64'd1);
        check({tag, " err_clr"}, 64'(err), 64'd0);
    endtask

    // Word k of the layer stream: position 0 of each group of PER is the bias.
    task automatic send_beat(input string tag, input int k, input logic last, input logic exp_done);
        int n;
        int p;
        n = k / PER;
        p = k % PER;
        s_tdata  = words[k];
        s_tvalid = 1'b1;
        s_tlast  = last;
        tick();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        if (p == 0) begin
            check($sformatf("%s w%0d bias_valid", tag, k), 64'(bias_valid), 64'(1 << n));
            check($sformatf("%s w%0d bias_value", tag, k), 64'(bias_value), 64'(words[k]));
            check($sformatf("%s w%0d weight_valid", tag, k), 64'(weight_valid), 64'd0);
        end else begin
            check($sformatf("%s w%0d weight_valid", tag, k), 64'(weight_valid), 64'd1);
            check($sformatf("%s w%0d weight_value", tag, k), 64'(weight_value), 64'(words[k]));
            check($sformatf("%s w%0d neuron_num", tag, k), 64'(cfg_neuron_num), 64'(FN + n));
            check($sformatf("%s w%0d bias_valid", tag, k), 64'(bias_valid), 64'd0);
        end
        check($sformatf("%s w%0d done", tag, k), 64'(done), 64'(exp_done));
        strobes += int'(weight_valid) + int'(bias_valid != '0);
    endtask

    task automatic quiet(input string tag);
        tick();
        check({tag, " weight_valid"}, 64'(weight_valid), 64'd0);
        check({tag, " bias_valid"}, 64'(bias_valid), 64'd0);
        check({tag, " done"}, 64'(done), 64'd0);
    endtask

    task automatic full_stream(input string tag, input logic gaps, input logic with_last);
        strobes = 0;
        for (int k = 0; k < 10; k++) begin
            send_beat(tag, k, with_last && (k == 9), k == 9);
            if (gaps && k != 9) quiet({tag, " gap"});
        end
        check({tag, " strobes"}, 64'(strobes), 64'(words_per_layer(NN, NW)));
        check({tag, " busy_end"}, 64'(busy), 64'd0);
        check({tag, " tready_end"}, 64'(s_tready), 64'd0);
        check({tag, " err"}, 64'(err), 64'(!with_last));
        quiet({tag, " post"});
    endtask

    initial begin
        words[0] = 16'h0010; words[1] = 16'h0001; words[2] = 16'h0002;
        words[3] = 16'h0003; words[4] = 16'h0004; words[5] = 16'h0020;
        words[6] = 16'h0005; words[7] = 16'h0006; words[8] = 16'h0007;
        words[9] = 16'h0008;
        rst = 1'b1; start = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
        tick();
        tick();
        check("rst tready", 64'(s_tready), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst err", 64'(err), 64'd0);
        check("rst layer", 64'(cfg_layer_num), 64'd1);
        check("rst neuron", 64'(cfg_neuron_num), 64'd0);
        rst = 1'b0;
        tick();

        // Back-to-back stream.
        do_start("t1");
        full_stream("t1", 1'b0, 1'b1);

        // Valid toggling 1,0,1,0.
        do_start("t2");
        full_stream("t2", 1'b1, 1'b1);

        // Early tlast on the third word aborts after forwarding it.
        do_start("t3");
        strobes = 0;
        send_beat("t3", 0, 1'b0, 1'b0);
        send_beat("t3", 1, 1'b0, 1'b0);
        send_beat("t3", 2, 1'b1, 1'b0);
        check("t3 err", 64'(err), 64'd1);
        check("t3 busy", 64'(busy), 64'd0);
        check("t3 tready", 64'(s_tready), 64'd0);
        quiet("t3 after");
        s_tvalid = 1'b1;
        s_tdata  = 16'hBEEF;
        quiet("t3 idle_valid");
        check("t3 idle_tready", 64'(s_tready), 64'd0);
        s_tvalid = 1'b0;
        check("t3 err_sticky", 64'(err), 64'd1);

        // Missing tlast: done still pulses, err set until the next start.
        do_start("t4");
        full_stream("t4", 1'b0, 1'b0);
        do_start("t4b");

        // Reset mid-load after 6 words, then a clean load.
        for (int k = 0; k < 6; k++) send_beat("t5", k, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5 rst tready", 64'(s_tready), 64'd0);
        check("t5 rst busy", 64'(busy), 64'd0);
        check("t5 rst wv", 64'(weight_value), 64'd0);
        check("t5 rst bv", 64'(bias_value), 64'd0);
        check("t5 rst neuron", 64'(cfg_neuron_num), 64'd0);
        check("t5 rst layer", 64'(cfg_layer_num), 64'd1);
        check("t5 rst valids", 64'({weight_valid, bias_valid, done}), 64'd0);
        quiet("t5 idle");
        do_start("t5b");
        full_stream("t5b", 1'b0, 1'b1);

        // start pulsed mid-load must not restart the counters.
        do_start("t6");
        strobes = 0;
        send_beat("t6", 0, 1'b0, 1'b0);
        send_beat("t6", 1, 1'b0, 1'b0);
        start = 1'b1;
        quiet("t6 start_busy");
        start = 1'b0;
        check("t6 busy", 64'(busy), 64'd1);
        for (int k = 2; k < 10; k++) send_beat("t6", k, k == 9, k == 9);
        check("t6 strobes", 64'(strobes), 64'd10);
        check("t6 err", 64'(err), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
